// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the multiplexed channel scanner.
package mux_scan_pkg;

   localparam int unsigned NCH  = 8;
   localparam int unsigned SELW = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      NEXT  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_next8.sv
// Cyclic next-set-bit search over an 8-bit mask, starting strictly after cur.
module rr_next8
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]  mask,
   input  logic [SELW-1:0] cur,
   output logic [SELW-1:0] nxt_c,
   output logic            wrap_c
);

   logic [SELW-1:0] idx;
   logic            found;

   // Offsets 1..NCH; offset NCH lands back on cur, so a lone bit at cur selects itself.
   always_comb begin
      nxt_c = cur;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = cur + SELW'(k);
         if (!found && mask[idx]) begin
            nxt_c = idx;
            found = 1'b1;
         end
      end
      wrap_c = (nxt_c <= cur);
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an 8-to-1 mux, dwelling DIV cycles on each,
// and publishes one snapshot per completed frame.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned DIV = 50000000
) (
   input  logic            IClk,
   input  logic            nRst,
   input  logic            EN,
   input  logic [NCH-1:0]  Mask,
   input  logic [NCH-1:0]  I,
   output logic [SELW-1:0] A,
   output logic            F,
   output logic [NCH-1:0]  Sample,
   output logic            Valid,
   output logic            Busy,
   output logic [7:0]      FrameCnt
);

   localparam int unsigned CW = $clog2(DIV);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]  shadow_q, shadow_d;
   logic [SELW-1:0] a_d;
   logic            f_d;
   logic [NCH-1:0]  sample_d;
   logic            valid_d;
   logic [7:0]      fcnt_d;

   logic [SELW-1:0] cur_sel;
   logic [SELW-1:0] nxt;
   logic            wrap;
   logic            mask_any;
   logic            tick;

   assign mask_any = |Mask;
   assign tick     = (cnt_q == CW'(DIV - 1));

   // Searching from the top index yields the lowest set bit for a fresh scan.
   assign cur_sel = (state_q == IDLE) ? SELW'(NCH - 1) : A;

   rr_next8 u_rr_next8 (
      .mask   (Mask),
      .cur    (cur_sel),
      .nxt_c  (nxt),
      .wrap_c (wrap)
   );

   always_ff @(posedge IClk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         A        <= '0;
         F        <= 1'b0;
         Sample   <= '0;
         Valid    <= 1'b0;
         Busy     <= 1'b0;
         FrameCnt <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         A        <= a_d;
         F        <= f_d;
         Sample   <= sample_d;
         Valid    <= valid_d;
         Busy     <= (state_d != IDLE);
         FrameCnt <= fcnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      a_d      = A;
      f_d      = F;
      sample_d = Sample;
      valid_d  = 1'b0;
      fcnt_d   = FrameCnt;

      unique case (state_q)
         IDLE: begin
            if (EN && mask_any) begin
               a_d      = nxt;
               shadow_d = '0;
               cnt_d    = '0;
               state_d  = DWELL;
            end
         end

         DWELL: begin
            if (!mask_any) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (tick) begin
               f_d         = I[A];
               shadow_d[A] = I[A];
               cnt_d       = '0;
               state_d     = NEXT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         NEXT: begin
            if (!mask_any || !EN) begin
               state_d = IDLE;
            end else begin
               a_d     = nxt;
               state_d = DWELL;
               // A search that does not move forward closes the frame.
               if (wrap) begin
                  sample_d = shadow_q & Mask;
                  valid_d  = 1'b1;
                  fcnt_d   = FrameCnt + 8'd1;
                  shadow_d = '0;
               end
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized scoreboard bench for mux_scan_ctrl with DIV=4.
module tb_mux_scan_ctrl;

   localparam int DIV = 4;
   localparam int SLOT = DIV + 1;
   localparam int NIV = 8192;

   logic       IClk = 1'b0;
   logic       nRst = 1'b0;
   logic       EN = 1'b0;
   logic [7:0] Mask = '0;
   logic [7:0] I = '0;
   logic [2:0] A;
   logic       F;
   logic [7:0] Sample;
   logic       Valid;
   logic       Busy;
   logic [7:0] FrameCnt;

   typedef struct {
      int         cyc;
      logic [7:0] smp;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] iv[NIV];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] fc = '0;

   mux_scan_ctrl #(.DIV(DIV)) dut (
      .IClk     (IClk),
      .nRst     (nRst),
      .EN       (EN),
      .Mask     (Mask),
      .I        (I),
      .A        (A),
      .F        (F),
      .Sample   (Sample),
      .Valid    (Valid),
      .Busy     (Busy),
      .FrameCnt (FrameCnt)
   );

   always #5 IClk = ~IClk;

   always @(posedge IClk) cyc++;

   // Input plan: the value sampled by posedge n is iv[n].
   always @(negedge IClk) I = iv[(cyc + 1) % NIV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every Valid pulse must match the head of the scoreboard.
   always @(negedge IClk) begin
      if (nRst && Valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(Sample), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            chk("sample", 32'(Sample), 32'(e.smp));
            chk("framecnt", 32'(FrameCnt), 32'(e.cnt));
         end
      end
   end

   task automatic fill_const(input logic [7:0] v, input int n);
      for (int i = cyc; i < cyc + n; i++) iv[i % NIV] = v;
   endtask

   function automatic logic ibit(input int t, input int ch);
      logic [7:0] v;
      v = iv[t % NIV];
      return v[ch];
   endfunction

   // Scan with the given mask; in slot s (s-th dwell since start) apply
   // mode 0: drop EN, 1: pulse reset, 2: clear Mask.
   task automatic scan(input logic [7:0] mask, input int s, input int mode);
      int ch[$];
      int m, e0, stop_cyc, end_cyc, nfr, k, cs;
      logic [7:0] smp;
      ch = {};
      for (int i = 0; i < 8; i++) if (mask[i]) ch.push_back(i);
      m = ch.size();
      @(negedge IClk);
      Mask = mask;
      EN   = 1'b1;
      e0   = cyc + 1;
      nfr  = s / m;
      for (int f = 0; f < nfr; f++) begin
         smp = '0;
         for (int j = 0; j < m; j++) smp[ch[j]] = ibit(e0 + SLOT * (f * m + j) + DIV, ch[j]);
         fc = fc + 8'd1;
         sb.push_back('{e0 + SLOT * m * (f + 1), smp, fc});
      end
      cs = ch[s % m];
      stop_cyc = e0 + SLOT * s + 1;
      while (cyc < stop_cyc) begin
         @(negedge IClk);
         k = (cyc - e0) / SLOT;
         chk("a_step", 32'(A), 32'(ch[k % m]));
         chk("busy_on", 32'(Busy), 32'd1);
      end
      if (mode == 0) begin
         EN = 1'b0;
         end_cyc = e0 + SLOT * (s + 1);
         while (cyc < end_cyc - 1) begin
            @(negedge IClk);
            chk("a_hold_en0", 32'(A), 32'(cs));
            chk("busy_en0", 32'(Busy), 32'd1);
         end
         @(negedge IClk);
         chk("idle_busy", 32'(Busy), 32'd0);
         chk("idle_a", 32'(A), 32'(cs));
         chk("idle_f", 32'(F), 32'(ibit(e0 + SLOT * s + DIV, cs)));
      end else if (mode == 1) begin
         #2;
         nRst = 1'b0;
         EN   = 1'b0;
         #1;
         chk("rst_a", 32'(A), 32'd0);
         chk("rst_f", 32'(F), 32'd0);
         chk("rst_sample", 32'(Sample), 32'd0);
         chk("rst_valid", 32'(Valid), 32'd0);
         chk("rst_busy", 32'(Busy), 32'd0);
         chk("rst_framecnt", 32'(FrameCnt), 32'd0);
         fc = '0;
         repeat (2) @(negedge IClk);
         nRst = 1'b1;
      end else begin
         Mask = '0;
         @(negedge IClk);
         chk("mask0_busy", 32'(Busy), 32'd0);
         chk("mask0_a", 32'(A), 32'(cs));
         if (s > 0) chk("mask0_f", 32'(F), 32'(ibit(e0 + SLOT * (s - 1) + DIV, ch[(s - 1) % m])));
         EN = 1'b0;
      end
      repeat (2) @(negedge IClk);
      chk("missing_valid", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NIV; i++) iv[i] = 8'($urandom);
      #1;
      chk("rst0_a", 32'(A), 32'd0);
      chk("rst0_busy", 32'(Busy), 32'd0);
      chk("rst0_valid", 32'(Valid), 32'd0);
      chk("rst0_framecnt", 32'(FrameCnt), 32'd0);
      repeat (3) @(negedge IClk);
      nRst = 1'b1;

      // Disabled: stays idle regardless of mask.
      Mask = 8'hFF;
      repeat (20) begin
         @(negedge IClk);
         chk("en0_busy", 32'(Busy), 32'd0);
         chk("en0_a", 32'(A), 32'd0);
         chk("en0_framecnt", 32'(FrameCnt), 32'd0);
      end
      // Enabled with empty mask: stays idle.
      Mask = 8'h00;
      EN   = 1'b1;
      repeat (10) begin
         @(negedge IClk);
         chk("mask0_idle_busy", 32'(Busy), 32'd0);
      end
      EN = 1'b0;

      fill_const(8'hA5, 200);
      scan(8'hFF, 8, 0);
      fill_const(8'hFF, 200);
      scan(8'b1000_0010, 6, 0);
      for (int i = 0; i < NIV; i++) iv[i] = 8'($urandom);
      scan(8'h10, 300, 0);
      scan(8'b0010_1001, 4, 0);
      scan(8'b0110_0001, 4, 1);
      scan(8'hFF, 8, 0);
      scan(8'b1100_0100, 2, 2);
      repeat (8) scan(8'($urandom_range(1, 255)), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 2)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
